// File: rtl/sub86_mdu.sv
// sub86_mdu: iterative multiply/divide unit, one bit per cycle.
// Handles MUL/IMUL (double-width product) and DIV/IDIV (quotient and
// remainder). Signed operations run on magnitudes, and the signs are fixed
// up in a single cycle at the end. Divide by zero skips the iteration.
module sub86_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic [WIDTH-1:0] RES_LO,
    output logic [WIDTH-1:0] RES_HI,
    output logic             BUSY,
    output logic             DONE,
    output logic             DZ,
    output logic             OVF
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        FIN  = 3'd4
    } state_t;

    // Two's complement negation helpers.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + ONE_2W;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r;        // latched raw operands
    logic [WIDTH-1:0]   dvs_r;           // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_r;           // product high half or partial remainder
    logic [WIDTH-1:0]   lo_r;            // multiplier/product low half or dividend/quotient
    logic [CW-1:0]      cnt_r;
    logic               res_sign_r, rem_sign_r, idiv_ovf_r;
    logic [WIDTH-1:0]   res_lo_r, res_hi_r;
    logic               busy_r, done_r, dz_r, ovf_r;

    logic               accept_s, div_zero_s, idiv_min_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     addend_s, sum_s, shl_s;
    logic               rem_ge_s;
    logic [WIDTH-1:0]   diff_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fix_lo_s, fix_hi_s;
    logic               fix_ovf_s;

    // Request decode: a START counts only when idle or finishing.
    always_comb begin
        accept_s   = START && ((state_r == IDLE) || (state_r == FIN));
        div_zero_s = OP[1] && (OPB == ZERO_W);
        idiv_min_s = (OP == 2'b11) && (OPA == MIN_W) && (OPB == ONES_W);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, FIN: begin
                if (accept_s) begin
                    state_nxt_s = div_zero_s ? FIN : PREP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PREP: state_nxt_s = ITER;
            ITER: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = ITER;
                end
            end
            FIX:     state_nxt_s = FIN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Arithmetic: magnitudes, one shift-add/restoring step, final sign fix-up.
    always_comb begin
        if (op_r[0] && a_r[WIDTH-1]) begin
            mag_a_s = neg_w(a_r);
        end else begin
            mag_a_s = a_r;
        end
        if (op_r[0] && b_r[WIDTH-1]) begin
            mag_b_s = neg_w(b_r);
        end else begin
            mag_b_s = b_r;
        end

        addend_s = lo_r[0] ? {1'b0, dvs_r} : {(WIDTH+1){1'b0}};
        sum_s    = {1'b0, acc_r} + addend_s;

        // The step remainder stays below the divisor, so a WIDTH-bit
        // difference is exact whenever the WIDTH+1-bit compare passes.
        shl_s    = {acc_r, lo_r[WIDTH-1]};
        rem_ge_s = (shl_s >= {1'b0, dvs_r});
        diff_s   = shl_s[WIDTH-1:0] - dvs_r;

        prod_s     = {acc_r, lo_r};
        prod_fix_s = res_sign_r ? neg_2w(prod_s) : prod_s;
        quo_s      = res_sign_r ? neg_w(lo_r) : lo_r;
        rem_s      = rem_sign_r ? neg_w(acc_r) : acc_r;

        if (op_r[1]) begin
            fix_lo_s = quo_s;
            fix_hi_s = rem_s;
        end else begin
            fix_lo_s = prod_fix_s[WIDTH-1:0];
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
        end

        case (op_r)
            2'b00:   fix_ovf_s = (fix_hi_s != ZERO_W);
            2'b01:   fix_ovf_s = (fix_hi_s != {WIDTH{fix_lo_s[WIDTH-1]}});
            2'b10:   fix_ovf_s = 1'b0;
            2'b11:   fix_ovf_s = idiv_ovf_r;
            default: fix_ovf_s = 1'b0;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            op_r       <= 2'b00;
            a_r        <= ZERO_W;
            b_r        <= ZERO_W;
            dvs_r      <= ZERO_W;
            acc_r      <= ZERO_W;
            lo_r       <= ZERO_W;
            cnt_r      <= CNT_ZERO;
            res_sign_r <= 1'b0;
            rem_sign_r <= 1'b0;
            idiv_ovf_r <= 1'b0;
            res_lo_r   <= ZERO_W;
            res_hi_r   <= ZERO_W;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dz_r       <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == PREP) || (state_nxt_s == ITER) || (state_nxt_s == FIX);
            done_r  <= (state_nxt_s == FIN);
            case (state_r)
                IDLE, FIN: begin
                    if (accept_s) begin
                        op_r       <= OP;
                        a_r        <= OPA;
                        b_r        <= OPB;
                        dz_r       <= div_zero_s;
                        ovf_r      <= 1'b0;
                        idiv_ovf_r <= idiv_min_s;
                        if (div_zero_s) begin
                            res_lo_r <= ONES_W;
                            res_hi_r <= OPA;
                        end
                    end
                end
                PREP: begin
                    res_sign_r <= op_r[0] & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    rem_sign_r <= op_r[0] & a_r[WIDTH-1];
                    cnt_r      <= CNT_INIT;
                    acc_r      <= ZERO_W;
                    if (op_r[1]) begin
                        dvs_r <= mag_b_s;
                        lo_r  <= mag_a_s;
                    end else begin
                        dvs_r <= mag_a_s;
                        lo_r  <= mag_b_s;
                    end
                end
                ITER: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (op_r[1]) begin
                        lo_r  <= {lo_r[WIDTH-2:0], rem_ge_s};
                        acc_r <= rem_ge_s ? diff_s : shl_s[WIDTH-1:0];
                    end else begin
                        acc_r <= sum_s[WIDTH:1];
                        lo_r  <= {sum_s[0], lo_r[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    res_lo_r <= fix_lo_s;
                    res_hi_r <= fix_hi_s;
                    ovf_r    <= fix_ovf_s;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign RES_LO = res_lo_r;
    assign RES_HI = res_hi_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign DZ     = dz_r;
    assign OVF    = ovf_r;

endmodule

// File: tb/tb_sub86_mdu.sv
// Self-checking bench for sub86_mdu (WIDTH=32): directed vector table,
// randomized operations against a plain-arithmetic reference model, and
// hand-written control sequences (ignored START, held START, reset abort).
module tb_sub86_mdu;

    logic        CLK = 1'b0;
    logic        RST, START;
    logic [1:0]  OP;
    logic [31:0] OPA, OPB;
    logic [31:0] RES_LO, RES_HI;
    logic        BUSY, DONE, DZ, OVF;

    int n_checks = 0;
    int n_errors = 0;

    sub86_mdu #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
        .RES_LO(RES_LO), .RES_HI(RES_HI), .BUSY(BUSY), .DONE(DONE),
        .DZ(DZ), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, lo, hi;
        logic        dz, ovf;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: full-precision integer arithmetic.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] lo, output logic [31:0] hi,
                                      output logic dz, output logic ovf);
        longint sa, sb, p, q, r, lim;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = 64'sd2147483648;
        dz  = 1'b0;
        ovf = 1'b0;
        lo  = 32'd0;
        hi  = 32'd0;
        if (op[1] && b == 32'd0) begin
            lo = 32'hFFFFFFFF;
            hi = a;
            dz = 1'b1;
        end else begin
            case (op)
                2'b00: begin
                    up = {32'd0, a} * {32'd0, b};
                    {hi, lo} = up;
                    ovf = (hi != 32'd0);
                end
                2'b01: begin
                    p = sa * sb;
                    {hi, lo} = p;
                    ovf = (p >= lim) || (p < -lim);
                end
                2'b10: begin
                    lo = a / b;
                    hi = a % b;
                end
                default: begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                    ovf = (q >= lim);
                end
            endcase
        end
    endfunction

    // Start one operation, scramble the inputs afterwards, wait for DONE.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt);
        @(negedge CLK);
        OP = op; OPA = a; OPB = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        OP = 2'($urandom); OPA = $urandom; OPB = $urandom;
        lat = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            if (BUSY) busy_cnt++;
            if (DONE) begin
                lat = k;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi,
                                 input logic dz, input logic ovf, input int lat);
        int got_lat, busy_cnt;
        run_op(op, a, b, got_lat, busy_cnt);
        check({tag, "_latency"}, 64'(got_lat), 64'(lat));
        check({tag, "_busy"}, 64'(busy_cnt), 64'(lat - 1));
        check({tag, "_res"}, {RES_HI, RES_LO}, {hi, lo});
        check({tag, "_flags"}, 64'({DZ, OVF}), 64'({dz, ovf}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, d1, d2, lat, busy_cnt;
        logic [31:0] a, b, elo, ehi, got_lo;
        logic [1:0]  op;
        logic        edz, eovf;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b1, 35};
        vecs[1]  = '{2'b01, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0, 1'b0, 35};
        vecs[2]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 35};
        vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 35};
        vecs[4]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 35};
        vecs[5]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 35};
        vecs[6]  = '{2'b10, 32'h1234,     32'd0,        32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0, 1};
        vecs[7]  = '{2'b10, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0, 1'b0, 35};
        vecs[8]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 35};
        vecs[9]  = '{2'b11, 32'h80000000, 32'd0,        32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1};
        vecs[10] = '{2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b1, 35};
        vecs[11] = '{2'b10, 32'd5,        32'd9,        32'd0,        32'd5,        1'b0, 1'b0, 35};

        RST = 1'b1; START = 1'b0; OP = 2'b00; OPA = 32'd0; OPB = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_flags", 64'({BUSY, DONE, DZ, OVF}), 64'd0);
        check("reset_res", {RES_HI, RES_LO}, 64'd0);
        RST = 1'b0;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].lo, vecs[i].hi, vecs[i].dz, vecs[i].ovf, vecs[i].lat);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            ref_model(op, a, b, elo, ehi, edz, eovf);
            run_and_check($sformatf("rnd%0d_op%0d", i, op), op, a, b, elo, ehi, edz, eovf,
                          (op[1] && b == 32'd0) ? 1 : 35);
        end

        // START pulsed mid-operation is ignored.
        @(negedge CLK);
        OP = 2'b00; OPA = 32'd3; OPB = 32'd5; START = 1'b1;
        @(posedge CLK); #1;
        nd = 0; d1 = 0; got_lo = 32'd0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 5) begin
                START = 1'b1; OP = 2'b10; OPA = 32'd99; OPB = 32'd99;
            end else begin
                START = 1'b0;
            end
            if (DONE) begin
                nd++;
                if (d1 == 0) begin
                    d1 = k;
                    got_lo = RES_LO;
                end
            end
            @(posedge CLK); #1;
        end
        check("ignore_done_count", 64'(nd), 64'd1);
        check("ignore_done_cycle", 64'(d1), 64'd35);
        check("ignore_result", 64'(got_lo), 64'd15);

        // START held through FIN: back-to-back operation.
        @(negedge CLK);
        OP = 2'b10; OPA = 32'd100; OPB = 32'd7; START = 1'b1;
        @(posedge CLK); #1;
        nd = 0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 75; k++) begin
            if (DONE) begin
                nd++;
                if (nd == 1) d1 = k;
                else if (nd == 2) d2 = k;
            end
            if (k == 70) START = 1'b0;
            @(posedge CLK); #1;
        end
        check("held_done_count", 64'(nd), 64'd2);
        check("held_done1_cycle", 64'(d1), 64'd35);
        check("held_done2_cycle", 64'(d2), 64'd70);
        check("held_result", {RES_HI, RES_LO}, {32'd2, 32'd14});

        // Reset mid-operation aborts, clears outputs, and no DONE follows.
        run_op(2'b10, 32'd5, 32'd0, lat, busy_cnt);
        check("pre_rst_dz", 64'(DZ), 64'd1);
        @(negedge CLK);
        OP = 2'b00; OPA = 32'hFFFFFFFF; OPB = 32'hFFFFFFFF; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        nd = 0;
        for (int k = 1; k <= 60; k++) begin
            RST = (k == 10);
            if (k == 11) begin
                check("rst_abort_flags", 64'({BUSY, DONE, DZ, OVF}), 64'd0);
                check("rst_abort_res", {RES_HI, RES_LO}, 64'd0);
            end
            if (k >= 11 && DONE) nd++;
            @(posedge CLK); #1;
        end
        check("rst_no_done", 64'(nd), 64'd0);

        // Reset wins over a simultaneous START.
        @(negedge CLK);
        OP = 2'b00; OPA = 32'd3; OPB = 32'd5; START = 1'b1; RST = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; RST = 1'b0;
        check("rst_prio_now", 64'({BUSY, DONE}), 64'd0);
        @(posedge CLK); #1;
        check("rst_prio_next", 64'({BUSY, DONE}), 64'd0);

        // Normal operation after reset.
        run_and_check("post_rst", 2'b10, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 35);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sub86_mdu.md
# sub86_mdu

Parametrised iterative multiply/divide unit for the sub86 core datapath, the successor to the hard-wired `mul`/`sml`/`sdv`/`div` micro-sequences. It executes unsigned and signed multiply (double-width product) and unsigned and signed divide (quotient and remainder) on WIDTH-bit operands, one bit per cycle. It also adds explicit divide-by-zero and overflow reporting. The core controller hands it operands with a START pulse, stalls on BUSY and writes results back on DONE.

## Interface
- WIDTH, 32: operand width in bits; must be ≥4 and even.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- START  in  1  operation request; sampled only when the unit is idle.
- OP  in  2  00 MUL unsigned, 01 IMUL signed, 10 DIV unsigned, 11 IDIV signed.
- OPA  in  WIDTH  multiplicand or dividend.
- OPB  in  WIDTH  multiplier or divisor.
- RES_LO  out  WIDTH  product low half, or quotient.
- RES_HI  out  WIDTH  product high half, or remainder.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse; results and flags are valid from this cycle.
- DZ  out  1  divide by zero (DIV/IDIV with OPB=0).
- OVF  out  1  result overflow (see Operation).

## Operation
- **States:** IDLE, PREP, ITER, FIX, FIN.
- **IDLE / FIN:**
  - START=1 latches OP, OPA and OPB, clears DZ and OVF, and moves to PREP.
  - DIV/IDIV with OPB=0 moves directly to FIN instead.
  - Without START, FIN returns to IDLE.
- **PREP:**
  - Signed ops replace each operand with its magnitude.
  - Records the result sign (signA^signB) and the remainder sign (signA).
  - Loads the iteration counter with WIDTH-1.
- **ITER (WIDTH cycles, counter decrements to 0):**
  - MUL: shift-add. If the multiplier LSB is 1, add the multiplicand to the upper accumulator. Shift the {acc, multiplier} pair right 1 bit.
  - DIV: restoring. Shift {rem, quotient} left 1 bit. If rem ≥ divisor, subtract it and set the quotient LSB.
- **FIX (one cycle):**
  - Signed MUL: if the result sign is 1, negate the 2·WIDTH product.
  - Signed DIV: negate the quotient if the result sign is 1; negate the remainder if the remainder sign is 1 (truncating division).
  - Registers RES_HI, RES_LO and OVF.
- **FIN:** DONE=1. Results and flags hold until the next accepted START or RST.
- **OVF rules:**
  - MUL: RES_HI≠0.
  - IMUL: RES_HI≠sign-extension of RES_LO[WIDTH-1].
  - IDIV: OPA=2^(WIDTH-1) and OPB=all ones; the natural result is Q=OPA, R=0.
  - DIV: always 0.
- **Divide by zero:** RES_LO=all ones, RES_HI=OPA, DZ=1, OVF=0.
- **Arithmetic widths:**
  - Magnitude of the most negative value is handled as a WIDTH-bit unsigned 2^(WIDTH-1).
  - The DIV compare/subtract is WIDTH+1 bits wide.
  - The MUL accumulator add keeps its carry-out (WIDTH+1 bits).
- START while BUSY=1 is ignored; the running operation continues unaffected.

## Timing
- Cycle 0 is the edge that samples START. States then run:
  - PREP: cycle 1.
  - ITER: cycles 2..WIDTH+1.
  - FIX: cycle WIDTH+2.
  - FIN: cycle WIDTH+3, with DONE=1.
- Latency is WIDTH+3 cycles (35 for WIDTH=32). The divide-by-zero path has latency 1.
- BUSY=1 in PREP, ITER and FIX; BUSY=0 in IDLE and FIN.
- Back-to-back operation: START during FIN is accepted, so the next DONE comes WIDTH+3 cycles later.
- RST (synchronous): state becomes IDLE and BUSY, DONE, DZ, OVF, RES_LO and RES_HI all become 0.
  - RST mid-operation aborts with no DONE.
  - RST has priority over a simultaneous START.
- Operands may change after the START edge without affecting the result.

## Test plan
All scenarios use WIDTH=32.

- **Unsigned multiply:** MUL 0xFFFFFFFF×0xFFFFFFFF → DONE at cycle 35, RES_HI=0xFFFFFFFE, RES_LO=0x00000001, OVF=1; BUSY high for cycles 1–34 only.
- **Signed multiply:** IMUL 0xFFFFFFF9 (−7)×6 → RES_HI=0xFFFFFFFF, RES_LO=0xFFFFFFD6, OVF=0. IMUL 0x00010000×0x00010000 → RES_HI=1, RES_LO=0, OVF=1.
- **Divide:** DIV 100/7 → RES_LO=14, RES_HI=2. IDIV −7/2 → RES_LO=0xFFFFFFFD, RES_HI=0xFFFFFFFF. IDIV 7/−2 → RES_LO=0xFFFFFFFD, RES_HI=1.
- **Divide by zero:** DIV 0x1234/0 → DONE at cycle 1, RES_LO=0xFFFFFFFF, RES_HI=0x1234, DZ=1. The following DIV 9/3 → DZ=0, RES_LO=3, RES_HI=0.
- **Signed overflow:** IDIV 0x80000000/0xFFFFFFFF → RES_LO=0x80000000, RES_HI=0, OVF=1 at cycle 35.
- **Control:**
  - START pulsed at cycle 5 of an operation is ignored; exactly one DONE occurs, at cycle 35.
  - START held through FIN gives a second DONE at cycle 70.
  - RST at cycle 10 → BUSY=0 and all outputs 0 at cycle 11; no DONE follows.
